// File: rtl/transpose_pingpong_ctrl.sv
// Address and bank sequencer for a ping-pong transpose frame buffer.
// Each ROW x CLO input frame is written row-major into one of two RAM banks.
// A full bank is then read column-major onto the output stream while the
// other bank fills. Only addresses, enables and flow-control flags pass
// through here; data goes straight to and from the RAM.
//
// Ports:
//   clk, rst              clock; synchronous reset, active low
//   s_axis_tvalid/tready  input beat handshake
//   wr_en/wr_bank/wr_addr RAM write port control
//   rd_en/rd_bank/rd_addr RAM read port control (RAM read data 1 cycle later)
//   m_axis_tvalid/tready  output beat handshake, aligned with RAM read data
//   m_axis_tlast          final beat of an output frame
//   wr_frame_done         1-cycle pulse after a bank finishes filling
//   rd_frame_done         1-cycle pulse after a bank finishes draining
module transpose_pingpong_ctrl #(
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned ROW        = 64,
  parameter int unsigned CLO        = 2400
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  wr_en,
  output logic                  wr_bank,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  rd_en,
  output logic                  rd_bank,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  wr_frame_done,
  output logic                  rd_frame_done
);

  localparam int unsigned RW = (ROW > 1) ? $clog2(ROW) : 1;
  localparam int unsigned CW = (CLO > 1) ? $clog2(CLO) : 1;
  localparam logic [RW-1:0]         ROW_LAST = RW'(ROW - 1);
  localparam logic [CW-1:0]         CLO_LAST = CW'(CLO - 1);
  localparam logic [ADDR_WIDTH-1:0] CLO_STEP = ADDR_WIDTH'(CLO);

  typedef enum logic [0:0] {R_IDLE = 1'b0, R_READ = 1'b1} rd_state_t;

  rd_state_t     state_q, state_nxt;
  logic [1:0]    bank_full;
  logic [RW-1:0] wr_row, rd_row;
  logic [CW-1:0] wr_col, rd_col;
  logic          wr_last, wr_done, rd_last, rd_done, rd_avail;
  logic [1:0]    set_mask, clr_mask;

  // Write side handshake; held off during reset and while the target bank is full
  assign s_axis_tready = rst & ~bank_full[wr_bank];
  assign wr_en         = s_axis_tvalid & s_axis_tready;
  assign wr_last       = (wr_row == ROW_LAST) && (wr_col == CLO_LAST);
  assign wr_done       = wr_en & wr_last;
  assign rd_last       = (rd_row == ROW_LAST) && (rd_col == CLO_LAST);
  assign rd_done       = rd_en & rd_last;

  // A bank completing this cycle counts as available so the first read is not delayed
  assign rd_avail = bank_full[rd_bank] | (wr_done & (wr_bank == rd_bank));

  assign set_mask = {wr_bank, ~wr_bank} & {2{wr_done}};
  assign clr_mask = {rd_bank, ~rd_bank} & {2{rd_done}};

  // Bank occupancy; writer and reader always touch different banks
  always_ff @(posedge clk) begin
    if (!rst) bank_full <= 2'b00;
    else      bank_full <= (bank_full | set_mask) & ~clr_mask;
  end

  // Row-major write counters; address is contiguous so it simply increments
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_bank       <= 1'b0;
      wr_row        <= '0;
      wr_col        <= '0;
      wr_addr       <= '0;
      wr_frame_done <= 1'b0;
    end else begin
      wr_frame_done <= wr_done;
      if (wr_en) begin
        if (wr_last) begin
          wr_bank <= ~wr_bank;
          wr_row  <= '0;
          wr_col  <= '0;
          wr_addr <= '0;
        end else if (wr_col == CLO_LAST) begin
          wr_col  <= '0;
          wr_row  <= wr_row + RW'(1);
          wr_addr <= wr_addr + ADDR_WIDTH'(1);
        end else begin
          wr_col  <= wr_col + CW'(1);
          wr_addr <= wr_addr + ADDR_WIDTH'(1);
        end
      end
    end
  end

  // Read FSM state register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= R_IDLE;
    else      state_q <= state_nxt;
  end

  // Read FSM next state
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      R_IDLE:  if (rd_avail) state_nxt = R_READ;
      R_READ:  if (rd_done)  state_nxt = R_IDLE;
      default: state_nxt = R_IDLE;
    endcase
  end

  // Read FSM output: issue a read only when the output slot is free or freeing
  always_comb begin
    rd_en = 1'b0;
    if (rst && (state_q == R_READ)) rd_en = !m_axis_tvalid || m_axis_tready;
  end

  // Column-major read counters: row is the inner loop, stepping the address by CLO
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_bank <= 1'b0;
      rd_row  <= '0;
      rd_col  <= '0;
      rd_addr <= '0;
    end else if (rd_en) begin
      if (rd_row == ROW_LAST) begin
        rd_row <= '0;
        if (rd_col == CLO_LAST) begin
          rd_col  <= '0;
          rd_addr <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          rd_col  <= rd_col + CW'(1);
          rd_addr <= ADDR_WIDTH'(rd_col) + ADDR_WIDTH'(1);
        end
      end else begin
        rd_row  <= rd_row + RW'(1);
        rd_addr <= rd_addr + CLO_STEP;
      end
    end
  end

  // Output valid/last follow the RAM read latency and hold until accepted
  always_ff @(posedge clk) begin
    if (!rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      rd_frame_done <= 1'b0;
    end else begin
      rd_frame_done <= m_axis_tvalid & m_axis_tready & m_axis_tlast;
      if (rd_en) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= rd_last;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_transpose_pingpong_ctrl.sv
// Scoreboard bench for transpose_pingpong_ctrl with a small two-bank RAM model.
// The driver pushes each completed input frame, transposed, into exp_q; the
// monitor pops on every accepted output beat and compares the RAM data.
module tb_transpose_pingpong_ctrl;
  localparam int unsigned AW  = 4;
  localparam int unsigned ROW = 4;
  localparam int unsigned CLO = 3;
  localparam int unsigned FN  = ROW * CLO;

  logic          clk, rst;
  logic          s_axis_tvalid, s_axis_tready;
  logic          wr_en, wr_bank, rd_en, rd_bank;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic          wr_frame_done, rd_frame_done;

  transpose_pingpong_ctrl #(.ADDR_WIDTH(AW), .ROW(ROW), .CLO(CLO)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .wr_frame_done(wr_frame_done), .rd_frame_done(rd_frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-bank RAM with registered read that holds when rd_en is low
  logic [15:0] mem0 [16];
  logic [15:0] mem1 [16];
  logic [15:0] ram_q;
  logic [15:0] s_data;
  always @(posedge clk) begin
    if (wr_en) begin
      if (wr_bank) mem1[wr_addr] <= s_data;
      else         mem0[wr_addr] <= s_data;
    end
    if (rd_en) ram_q <= rd_bank ? mem1[rd_addr] : mem0[rd_addr];
  end

  // Downstream ready: 0 = always, 1 = pattern 1,0,0,1, 2 = stalled
  int rmode = 0;
  bit [1:0] phase;
  always @(posedge clk) phase <= phase + 2'd1;
  always_comb begin
    m_axis_tready = 1'b1;
    if (rmode == 1)      m_axis_tready = (phase == 2'd0) || (phase == 2'd3);
    else if (rmode == 2) m_axis_tready = 1'b0;
  end

  int chk_m = 0, err_m = 0;   // main-thread checks
  int chk_s = 0, err_s = 0;   // monitor checks

  task automatic check_m(string name, logic [31:0] act, logic [31:0] exp);
    chk_m++;
    if (act !== exp) begin
      err_m++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_s(string name, logic [31:0] act, logic [31:0] exp);
    chk_s++;
    if (act !== exp) begin
      err_s++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: expected output stream, pushed only by the driver
  logic [15:0] exp_q [$];
  logic [15:0] fb [FN];
  int bi = 0, wr_par = 0, acc_cnt = 0, stall_cnt = 0;

  // Monitor-owned state
  int mon_ptr = 0, rd_idx = 0, rd_par = 0, out_beats = 0;
  int wr_done_cnt = 0, rd_done_cnt = 0;
  bit prev_stall = 0, prev_last = 0;
  logic [15:0] prev_data;

  always @(negedge clk) begin
    if (!rst) begin
      mon_ptr    = exp_q.size();
      rd_idx     = 0;
      rd_par     = 0;
      out_beats  = 0;
      prev_stall = 0;
    end else begin
      if (wr_frame_done) wr_done_cnt++;
      if (rd_frame_done) rd_done_cnt++;
      if (prev_stall) begin
        check_s("hold_valid", m_axis_tvalid, 1);
        check_s("hold_data", ram_q, prev_data);
        check_s("hold_last", m_axis_tlast, prev_last);
      end
      if (rd_en) begin
        check_s("rd_addr", rd_addr, (rd_idx % ROW) * CLO + rd_idx / ROW);
        check_s("rd_bank", rd_bank, rd_par);
        rd_idx++;
        if (rd_idx == FN) begin
          rd_idx = 0;
          rd_par ^= 1;
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (mon_ptr >= exp_q.size()) check_s("out_unexpected_beat", 1, 0);
        else begin
          check_s("out_data", ram_q, exp_q[mon_ptr]);
          mon_ptr++;
        end
        check_s("out_tlast", m_axis_tlast, (out_beats == FN - 1) ? 1 : 0);
        out_beats = (out_beats + 1) % FN;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = ram_q;
      prev_last  = m_axis_tlast;
    end
  end

  // Send n beats; gap idle cycles after each accepted beat
  task automatic send_beats(int n, int gap);
    logic [15:0] v;
    int waitc;
    bit acc;
    for (int k = 0; k < n; k++) begin
      v = 16'($urandom);
      waitc = 0;
      acc = 0;
      s_data = v;
      s_axis_tvalid = 1'b1;
      while (!acc) begin
        @(negedge clk);
        if (s_axis_tready) begin
          acc = 1;
          check_m("wr_en", wr_en, 1);
          check_m("wr_addr", wr_addr, bi);
          check_m("wr_bank", wr_bank, wr_par);
        end else begin
          stall_cnt++;
          waitc++;
        end
        @(posedge clk); #1;
        if (waitc > 200) begin
          check_m("s_tready_timeout", 0, 1);
          s_axis_tvalid = 1'b0;
          return;
        end
      end
      fb[bi] = v;
      bi++;
      acc_cnt++;
      if (bi == FN) begin
        for (int c = 0; c < CLO; c++)
          for (int r = 0; r < ROW; r++)
            exp_q.push_back(fb[r * CLO + c]);
        bi = 0;
        wr_par ^= 1;
      end
      if (gap > 0) begin
        s_axis_tvalid = 1'b0;
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          check_m("gap_wr_en", wr_en, 0);
          check_m("gap_wr_addr_hold", wr_addr, bi);
          @(posedge clk); #1;
        end
      end
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((mon_ptr != exp_q.size()) || m_axis_tvalid) begin
      @(posedge clk); #1;
      n++;
      if (n > 1000) begin
        check_m("drain_timeout", 0, 1);
        break;
      end
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic check_pulses(int wd0, int rd0, int frames);
    check_m("wr_frame_done_count", wr_done_cnt - wd0, frames);
    check_m("rd_frame_done_count", rd_done_cnt - rd0, frames);
  endtask

  int wd0, rd0;

  initial begin
    rst = 1'b0;
    s_axis_tvalid = 1'b0;
    s_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_m("rst_s_tready", s_axis_tready, 0);
    check_m("rst_wr_en", wr_en, 0);
    check_m("rst_rd_en", rd_en, 0);
    check_m("rst_m_tvalid", m_axis_tvalid, 0);
    check_m("rst_m_tlast", m_axis_tlast, 0);
    check_m("rst_done", {wr_frame_done, rd_frame_done}, 0);
    check_m("rst_addrs", {wr_addr, rd_addr}, 0);
    check_m("rst_banks", {wr_bank, rd_bank}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_m("post_rst_s_tready", s_axis_tready, 1);
    @(posedge clk); #1;

    // 1: single frame with latency check
    wd0 = wr_done_cnt; rd0 = rd_done_cnt;
    send_beats(FN, 0);
    @(negedge clk);
    check_m("lat_rd_en_T1", rd_en, 1);
    check_m("lat_m_tvalid_T1", m_axis_tvalid, 0);
    @(negedge clk);
    check_m("lat_m_tvalid_T2", m_axis_tvalid, 1);
    wait_drain();
    check_pulses(wd0, rd0, 1);

    // 2: five frames back-to-back
    wd0 = wr_done_cnt; rd0 = rd_done_cnt;
    for (int f = 0; f < 5; f++) begin
      stall_cnt = 0;
      send_beats(FN, 0);
      if (f >= 2) check_m("s2_stall_le2", (stall_cnt <= 2) ? 1 : 0, 1);
    end
    wait_drain();
    check_pulses(wd0, rd0, 5);

    // 3: downstream ready 1,0,0,1
    wd0 = wr_done_cnt; rd0 = rd_done_cnt;
    rmode = 1;
    send_beats(2 * FN, 0);
    wait_drain();
    rmode = 0;
    check_pulses(wd0, rd0, 2);

    // 4: downstream stalled 40 cycles while feeding 3 frames
    wd0 = wr_done_cnt; rd0 = rd_done_cnt;
    acc_cnt = 0;
    rmode = 2;
    fork
      send_beats(3 * FN, 0);
      begin
        repeat (40) @(posedge clk);
        @(negedge clk);
        check_m("s4_accepted_before_full", acc_cnt, 2 * FN);
        check_m("s4_s_tready_low", s_axis_tready, 0);
        rmode = 0;
      end
    join
    wait_drain();
    check_pulses(wd0, rd0, 3);

    // 5: reset after 7 beats discards the partial frame
    wd0 = wr_done_cnt; rd0 = rd_done_cnt;
    send_beats(7, 0);
    rst = 1'b0;
    @(negedge clk);
    check_m("s5_rst_s_tready", s_axis_tready, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    bi = 0;
    wr_par = 0;
    @(negedge clk);
    check_m("s5_m_tvalid", m_axis_tvalid, 0);
    check_m("s5_wr_addr", wr_addr, 0);
    check_m("s5_s_tready", s_axis_tready, 1);
    check_m("s5_wr_bank", wr_bank, 0);
    @(posedge clk); #1;
    send_beats(FN, 0);
    wait_drain();
    check_pulses(wd0, rd0, 1);

    // 6: input gapped 1-on / 2-off
    wd0 = wr_done_cnt; rd0 = rd_done_cnt;
    send_beats(2 * FN, 2);
    wait_drain();
    check_pulses(wd0, rd0, 2);

    $display("CHECKS %0d ERRORS %0d", chk_m + chk_s, err_m + err_s);
    $finish;
  end

endmodule
